// File: rtl/rx_key_fifo.sv
// Byte-to-word assembler (MSB-first) feeding a small FIFO of completed words.
// A completed word is pushed at the edge that accepts its final byte, or dropped with a sticky overrun flag.
module rx_key_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 2
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic [7:0]                  byte_in,
  input  logic                        byte_valid,
  input  logic                        frame_abort,
  input  logic                        key_ready,
  input  logic                        clear_err,
  output logic [DATA_W-1:0]           key_out,
  output logic                        key_valid,
  output logic [$clog2(DEPTH):0]      key_count,
  output logic [$clog2(DATA_W/8)-1:0] byte_idx,
  output logic                        overrun
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(NB);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Output handshake: a word transfers on any edge where key_valid and key_ready are both 1;
  // key_valid never depends on key_ready, and key_out is stable while key_valid is held.

  logic [DATA_W-1:0] asm_q;
  logic [DATA_W-1:0] asm_fill;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              last_byte;
  logic              accept;
  logic              complete;
  logic              pop;
  logic              full;
  logic              push;
  logic              drop;

  // Assembly register with the incoming byte merged at its MSB-first position.
  always_comb begin
    asm_fill = asm_q;
    asm_fill[DATA_W-1-8*int'(byte_idx) -: 8] = byte_in;
  end

  assign last_byte = (byte_idx == IDX_W'(NB - 1));
  assign accept    = byte_valid && !frame_abort;
  assign complete  = accept && last_byte;
  assign pop       = key_valid && key_ready;
  assign full      = (key_count == CNT_W'(DEPTH));
  assign push      = complete && (!full || pop);
  assign drop      = complete && !push;

  assign key_valid = (key_count != '0);
  assign key_out   = key_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      byte_idx <= '0;
      asm_q    <= '0;
    end else if (frame_abort) begin
      byte_idx <= '0;
      asm_q    <= '0;
    end else if (byte_valid) begin
      if (last_byte) begin
        byte_idx <= '0;
        asm_q    <= '0;
      end else begin
        byte_idx <= byte_idx + IDX_W'(1);
        asm_q    <= asm_fill;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= asm_fill;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      key_count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   key_count <= key_count + CNT_W'(1);
        2'b01:   key_count <= key_count - CNT_W'(1);
        default: key_count <= key_count;
      endcase
    end
  end

  // A fresh drop takes priority over clear_err in the same cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)         overrun <= 1'b0;
    else if (drop)      overrun <= 1'b1;
    else if (clear_err) overrun <= 1'b0;
  end

endmodule
